// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start in, status and result out.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one mux-based full-adder cell plus a carry flop,
// LSB first, result assembled in a shift register over WIDTH cycles.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shift_a, shift_b, sum_sr;
  logic [CW-1:0]    cnt;
  logic             carry, cout_r, busy_r, done_r;
  logic             load, step, last, busy_d, done_d;
  logic             fa_s, fa_c, fa_p;

  // Mux-based full adder on the current LSBs and the carry flop.
  assign fa_p = shift_a[0] ^ shift_b[0];
  assign fa_s = fa_p ^ carry;
  assign fa_c = fa_p ? carry : shift_a[0];
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status flags are registered from the next state so they align with it.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_a <= '0;
      shift_b <= '0;
      sum_sr  <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= busy_d;
      done_r <= done_d;
      if (load) begin
        shift_a <= bus.a;
        shift_b <= bus.b;
        carry   <= bus.cin;
        cnt     <= '0;
        sum_sr  <= '0;
      end else if (step) begin
        shift_a <= {1'b0, shift_a[WIDTH-1:1]};
        shift_b <= {1'b0, shift_b[WIDTH-1:1]};
        sum_sr  <= {fa_s, sum_sr[WIDTH-1:1]};
        carry   <= fa_c;
        cnt     <= cnt + CW'(1);
        if (last) cout_r <= fa_c;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_sr;
  assign bus.cout = cout_r;
endmodule
